// File: rtl/div_seq_pkg.sv
// Shared constants and helpers for the sequential 32-bit divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam int   DIV_STEPS            = 32;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU): one quotient bit per cycle,
// result {remainder, quotient} held while ready is high.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  div_state_e  state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] work_reg;
  logic [31:0] divisor_reg;
  logic        neg_quo_reg;
  logic        neg_rem_reg;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] trial;
  logic        trial_ge;
  logic [64:0] work_next;

  // work_reg layout: [64:33] partial remainder, [32:1] remaining dividend
  // bits shifting up, [31:0] collects quotient bits from the bottom.
  always_comb begin
    mag1      = neg_if(signed_div & opdata1[31], opdata1);
    mag2      = neg_if(signed_div & opdata2[31], opdata2);
    trial     = work_reg[64:32] - {1'b0, divisor_reg};
    trial_ge  = work_reg[64] | ~trial[32];
    work_next = trial_ge ? {trial[31:0], work_reg[31:0], 1'b1}
                         : {work_reg[63:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DIV_FREE;
      cnt_reg     <= 6'd0;
      work_reg    <= 65'd0;
      divisor_reg <= 32'd0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result      <= 64'd0;
      ready       <= DIV_RESULT_NOT_READY;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        DIV_FREE: begin
          if (start == DIV_START && !annul) begin
            busy <= 1'b1;
            if (opdata2 == 32'd0) begin
              state_reg <= DIV_BYZERO;
            end else begin
              state_reg   <= DIV_ON;
              cnt_reg     <= 6'd0;
              work_reg    <= {32'd0, mag1, 1'b0};
              divisor_reg <= mag2;
              neg_quo_reg <= signed_div & (opdata1[31] ^ opdata2[31]);
              neg_rem_reg <= signed_div & opdata1[31];
            end
          end
        end
        DIV_BYZERO: begin
          // Zero the working state so the END recompute also yields 0.
          state_reg   <= DIV_END;
          work_reg    <= 65'd0;
          neg_quo_reg <= 1'b0;
          neg_rem_reg <= 1'b0;
          result      <= 64'd0;
          busy        <= 1'b0;
        end
        DIV_ON: begin
          if (annul) begin
            state_reg <= DIV_FREE;
            busy      <= 1'b0;
          end else begin
            work_reg <= work_next;
            cnt_reg  <= cnt_reg + 6'd1;
            if (cnt_reg == 6'(DIV_STEPS - 1)) begin
              state_reg <= DIV_END;
              busy      <= 1'b0;
            end
          end
        end
        DIV_END: begin
          if (start == DIV_STOP) begin
            state_reg <= DIV_FREE;
            ready     <= DIV_RESULT_NOT_READY;
          end else begin
            result <= {neg_if(neg_rem_reg, work_reg[64:33]),
                       neg_if(neg_quo_reg, work_reg[31:0])};
            ready  <= DIV_RESULT_READY;
          end
        end
        default: state_reg <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned values, divide by
// zero, annul and reset mid-operation.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready after the accepting edge; returns edges elapsed.
  task automatic wait_ready(output int k);
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int k;
    signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
    tick();
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " ready_early"}, 64'(ready), 64'd0);
    // Scramble operands after the latch edge.
    opdata1 = ~a; opdata2 = b ^ 32'h5; signed_div = ~sgn;
    wait_ready(k);
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " result"}, result, exp);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check({tag, " hold_ready"}, 64'(ready), 64'd1);
    check({tag, " hold_result"}, result, exp);
    start = 1'b0;
    tick();
    check({tag, " release"}, {62'd0, ready, busy}, 64'd0);
    $display("op %s sgn=%0d a=%h b=%h result=%h latency=%0d", tag, sgn, a, b, result, k);
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);

    run_op("divu_1100_20", 1'b0, 32'h0000_1100, 32'h0000_0020, {32'h0, 32'h0000_0088}, 33);
    run_op("div_40_m32", 1'b1, 32'h0000_0028, 32'hFFFF_FFE0, {32'h0000_0008, 32'hFFFF_FFFF}, 33);
    run_op("div_m32_40", 1'b1, 32'hFFFF_FFE0, 32'h0000_0028, {32'hFFFF_FFE0, 32'h0000_0000}, 33);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run_op("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 33);
    run_op("divu_max_7", 1'b0, 32'hFFFF_FFFF, 32'h0000_0007, {32'h0000_0003, 32'h2492_4924}, 33);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("div_by_zero", 1'b1, 32'h1234_5678, 32'h0000_0000, 64'd0, 2);

    // Start together with annul in FREE must be ignored.
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
    tick();
    check("start_annul busy", 64'(busy), 64'd0);
    start = 1'b0; annul = 1'b0;
    tick();
    $display("op start_with_annul busy=%0d", busy);

    // Put a known nonzero result in place, then annul the next op at step 10.
    run_op("divu_100_3", 1'b0, 32'd100, 32'd3, {32'd1, 32'd33}, 33);
    opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul = 1'b1; start = 1'b0;
    tick();
    annul = 1'b0;
    check("annul busy", 64'(busy), 64'd0);
    check("annul ready", 64'(ready), 64'd0);
    check("annul result_kept", result, {32'd1, 32'd33});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("annul quiet", 64'(seen), 64'd0);
    $display("op annul_step10 result=%h", result);
    run_op("after_annul", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 33);

    // Reset in the middle of ON, with start held throughout.
    signed_div = 1'b0; opdata1 = 32'hFFFF_FFFF; opdata2 = 32'd7; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_on outputs", {result, 62'd0, ready, busy} != 128'd0 ? 64'd1 : 64'd0, 64'd0);
    tick();
    check("rst_on restart busy", 64'(busy), 64'd1);
    wait_ready(k);
    check("rst_on restart latency", 64'(k), 64'd33);
    check("rst_on restart result", result, {32'd3, 32'h2492_4924});
    $display("op rst_mid_on result=%h latency=%0d", result, k);

    // Reset while in END with start still held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_end result", result, 64'd0);
    check("rst_end flags", {62'd0, ready, busy}, 64'd0);
    tick();
    check("rst_end restart busy", 64'(busy), 64'd1);
    wait_ready(k);
    check("rst_end restart latency", 64'(k), 64'd33);
    check("rst_end restart result", result, {32'd3, 32'h2492_4924});
    start = 1'b0;
    tick();
    check("rst_end release", {62'd0, ready, busy}, 64'd0);
    $display("op rst_in_end result=%h latency=%0d", result, k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port signed_div, input, 1: 1 = signed DIV, 0 = unsigned DIVU; sampled with start.
REQ-004 SHALL have port opdata1, input, 32, the dividend (rs).
REQ-005 SHALL have port opdata2, input, 32, the divisor (rt).
REQ-006 SHALL have port start, input, 1, a level request held high by the EX stage until ready is seen.
REQ-007 SHALL have port annul, input, 1, which aborts the operation in flight (branch flush or exception).
REQ-008 SHALL have port result, output, 64: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready, output, 1, asserted while result is valid.
REQ-010 SHALL have port busy, output, 1, the pipeline stall request; high in every state except FREE and END.

Function
REQ-011 SHALL implement a 4-state FSM with states FREE, BYZERO, ON and END.
REQ-012 FREE: start=1, annul=0, opdata2!=0 -> latch the operands and signed_div, clear the 6-bit counter, go to ON.
REQ-013 FREE: start=1, annul=0, opdata2==0 -> go to BYZERO; annul=1 or start=0 -> stay in FREE.
REQ-014 BYZERO: next edge -> END with result=64'h0.
REQ-015 ON: perform one restoring shift-subtract step per cycle, using a 33-bit trial subtract on the 65-bit working register.
REQ-016 ON: exit to END after exactly 32 steps, so that for start sampled at edge N, ready=1 first after edge N+33.
REQ-017 ON: annul=1 -> go to FREE at the next edge, with ready=0 and result unchanged; annul has priority over step completion.
REQ-018 END: ready=1 and result held; stay in END while start=1; go to FREE on start=0.
REQ-019 ready SHALL be 0 in every state except END.
REQ-020 Signed mode: divide the magnitudes, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0; no trap.
REQ-022 Operand changes on opdata1, opdata2 or signed_div after the latch SHALL not affect the operation in flight.
REQ-023 annul asserted in FREE or END SHALL have no effect.
REQ-024 start rising in the same cycle as annul=1 SHALL not be accepted.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to result or ready.

Reset
REQ-026 rst=1 at any edge SHALL force FREE, result=64'h0, ready=0, busy=0, counter=0, including mid-ON and mid-END.
REQ-027 rst SHALL override start and annul in the same cycle.

Structure
REQ-028 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady and DivStart/Stop SHALL be defined in define.v alongside the existing global constants.
REQ-029 SHALL be a single flat module; no sub-module is required.
REQ-030 SHALL be instantiated beside EX, with the EX/MEM HI/LO write sourced from result and busy ORed into the pipeline stall controller.

Verification
REQ-031 Unsigned 0x00001100 / 0x00000020 -> result {0x00000000, 0x00000088}, ready first after edge N+33.
REQ-032 Signed 0x00000028 / 0xFFFFFFE0 (40 / -32) -> result {0x00000008, 0xFFFFFFFF}.
REQ-033 Signed 0xFFFFFFE0 / 0x00000028 (-32 / 40) -> result {0xFFFFFFE0, 0x00000000}; signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-034 Divisor 0 -> BYZERO then END, ready after edge N+2 with result 64'h0.
REQ-035 annul pulsed at step 10 -> FREE next cycle, ready never rises; a following start completes normally with correct values.
REQ-036 rst asserted while in ON, and again while in END with start held -> all outputs 0 at the next edge; start still high afterwards begins a fresh operation from FREE.
